// File: rtl/mux_scan_serializer_pkg.sv
// Shared constants, state encoding and sizing helper for the mux scan serializer.
// Imported by the top and the bit-period counter.
package mux_scan_serializer_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Hold counter only needs to reach BIT_CYCLES-1; keep at least one bit.
  function automatic int hold_cnt_w(input int bit_cycles);
    return (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Purely combinational 4:1 mux; W is indexed [0:3] and S selects W[S].
module mux4to1 (
  input  logic [0:3] W,
  input  logic [1:0] S,
  output logic       f
);

  assign f = W[S];

endmodule

// File: rtl/mux_scan_serializer_bit_period_counter.sv
// Counts the cycles a select value is held; tc marks the final hold cycle.
// Counts up from 0 and wraps to 0 on the cycle after tc.
module mux_scan_serializer_bit_period_counter
  import mux_scan_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = hold_cnt_w(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial controller driving a 4:1 mux: latches a word onto W,
// steps S through 00..11 and registers the fed-back mux output as a bit stream.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [0:3] load_data,
  output logic [0:3] word,
  output logic [1:0] sel,
  input  logic       mux_f,
  output logic       ser_data,
  output logic       ser_valid,
  output logic       ser_last,
  output logic       busy
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  state_t           state_q, state_d;
  logic [0:3]       word_q, word_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;

  logic tc;
  logic bit_end;
  logic accept;

  mux_scan_serializer_bit_period_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_period_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .enable(state_q == SCAN),
    .tc    (tc)
  );

  // Ready in the last hold cycle of the last bit lets a new word follow with no bubble.
  assign load_ready = (state_q == IDLE) || (tc && (sel_q == LAST_SEL));
  assign accept     = load_valid && load_ready;
  assign bit_end    = (state_q == SCAN) && tc;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sel_d       = sel_q;
    ser_data_d  = ser_data_q;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;

    if (bit_end) begin
      ser_data_d  = mux_f;
      ser_valid_d = 1'b1;
      ser_last_d  = (sel_q == LAST_SEL);
      sel_d       = sel_q + SEL_W'(1);
      if (sel_q == LAST_SEL) begin
        state_d = IDLE;
      end
    end

    if (accept) begin
      word_d  = load_data;
      sel_d   = '0;
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      sel_q       <= '0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign word      = word_q;
  assign sel       = sel_q;
  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q == SCAN);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: one serializer+mux pair at BIT_CYCLES=1 and one at BIT_CYCLES=3.
module tb_mux_scan_serializer;

  logic clk;
  logic rst_n;

  logic       lv1, lr1, f1, sd1, sv1, sl1, bz1;
  logic [0:3] ld1, w1;
  logic [1:0] s1;

  logic       lv3, lr3, f3, sd3, sv3, sl3, bz3;
  logic [0:3] ld3, w3;
  logic [1:0] s3;

  int n_cmp;
  int n_fail;

  mux_scan_serializer #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .word(w1), .sel(s1), .mux_f(f1), .ser_data(sd1), .ser_valid(sv1),
    .ser_last(sl1), .busy(bz1)
  );
  mux4to1 mux1 (.W(w1), .S(s1), .f(f1));

  mux_scan_serializer #(.BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv3), .load_ready(lr3), .load_data(ld3),
    .word(w3), .sel(s3), .mux_f(f3), .ser_data(sd3), .ser_valid(sv3),
    .ser_last(sl3), .busy(bz3)
  );
  mux4to1 mux3 (.W(w3), .S(s3), .f(f3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({w1, s1, sd1, sv1, sl1, bz1} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: got w=%b s=%b d=%b v=%b l=%b busy=%b, want all 0",
               w1, s1, sd1, sv1, sl1, bz1);
    end
    n_cmp++;
    if ({w3, s3, sd3, sv3, sl3, bz3} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_dut3: got w=%b s=%b d=%b v=%b l=%b busy=%b, want all 0",
               w3, s3, sd3, sv3, sl3, bz3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (lr1 !== 1'b1 || lr3 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got lr1=%b lr3=%b, want 1 1", lr1, lr3);
    end
  endtask

  // Loads one word into dut1 and checks sel stepping, bit stream, last marker and busy.
  task automatic test_word_bc1(input logic [0:3] w, input logic [0:3] exp_bits, input string tag);
    logic [1:0] exp_sel;
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = w;
    n_cmp++;
    if (lr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_idle: got %b want 1", tag, lr1);
    end
    @(negedge clk);
    lv1 = 1'b0;
    ld1 = 4'b0;
    n_cmp++;
    if (bz1 !== 1'b1 || w1 !== w || sv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: got busy=%b word=%b v=%b want 1 %b 0", tag, bz1, w1, sv1, w);
    end
    for (int i = 0; i < 4; i++) begin
      exp_sel = 2'(i);
      n_cmp++;
      if (s1 !== exp_sel || lr1 !== (i == 3)) begin
        n_fail++;
        $display("FAIL %s_sel%0d: got sel=%b ready=%b want %b %b", tag, i, s1, lr1, exp_sel, (i == 3));
      end
      @(negedge clk);
      n_cmp++;
      if (sv1 !== 1'b1 || sd1 !== exp_bits[i] || sl1 !== (i == 3)) begin
        n_fail++;
        $display("FAIL %s_bit%0d: got v=%b d=%b l=%b want 1 %b %b",
                 tag, i, sv1, sd1, sl1, exp_bits[i], (i == 3));
      end
    end
    n_cmp++;
    if (bz1 !== 1'b0 || lr1 !== 1'b1 || s1 !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_done: got busy=%b ready=%b sel=%b want 0 1 00", tag, bz1, lr1, s1);
    end
    @(negedge clk);
    n_cmp++;
    if (sv1 !== 1'b0 || sl1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_quiet: got v=%b l=%b want 0 0", tag, sv1, sl1);
    end
  endtask

  task automatic test_basic();
    test_word_bc1(4'b1010, 4'b1010, "w1010");
    test_word_bc1(4'b0111, 4'b0111, "w0111");
  endtask

  task automatic test_back_to_back();
    logic [0:7] exp_bits;
    exp_bits = 8'b1010_0111;
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 4'b1010;
    @(negedge clk);
    ld1 = 4'b0111;
    n_cmp++;
    if (lr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready0: got %b want 0", lr1);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sv1 !== 1'b1 || sd1 !== exp_bits[i-1] || sl1 !== (i == 4 || i == 8)) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: got v=%b d=%b l=%b want 1 %b %b",
                 i, sv1, sd1, sl1, exp_bits[i-1], (i == 4 || i == 8));
      end
      if (i < 8) begin
        n_cmp++;
        if (lr1 !== (i == 3 || i == 7)) begin
          n_fail++;
          $display("FAIL b2b_ready%0d: got %b want %b", i, lr1, (i == 3 || i == 7));
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (w1 !== 4'b0111 || bz1 !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_second_word: got word=%b busy=%b want 0111 1", w1, bz1);
        end
        lv1 = 1'b0;
        ld1 = 4'b0;
      end
    end
    n_cmp++;
    if (bz1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b want 0", bz1);
    end
    @(negedge clk);
  endtask

  task automatic test_bit_cycles3();
    logic [0:3] exp_bits;
    logic [1:0] exp_sel;
    logic       exp_v;
    exp_bits = 4'b1010;
    @(negedge clk);
    lv3 = 1'b1;
    ld3 = 4'b1010;
    @(negedge clk);
    lv3 = 1'b0;
    ld3 = 4'b0;
    for (int j = 0; j < 12; j++) begin
      exp_sel = 2'(j / 3);
      n_cmp++;
      if (s3 !== exp_sel || bz3 !== 1'b1) begin
        n_fail++;
        $display("FAIL bc3_sel_c%0d: got sel=%b busy=%b want %b 1", j, s3, bz3, exp_sel);
      end
      @(negedge clk);
      exp_v = ((j + 1) % 3 == 0);
      n_cmp++;
      if (sv3 !== exp_v || sl3 !== (j == 11) || (exp_v && sd3 !== exp_bits[j / 3])) begin
        n_fail++;
        $display("FAIL bc3_out_c%0d: got v=%b d=%b l=%b want v=%b d=%b l=%b",
                 j + 1, sv3, sd3, sl3, exp_v, exp_bits[j / 3], (j == 11));
      end
    end
    n_cmp++;
    if (bz3 !== 1'b0 || lr3 !== 1'b1) begin
      n_fail++;
      $display("FAIL bc3_done: got busy=%b ready=%b want 0 1", bz3, lr3);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_load();
    logic [0:3] got;
    got = 4'b0;
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 4'b0000;
    @(negedge clk);
    ld1 = 4'b1111;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) begin
        lv1 = 1'b0;
        ld1 = 4'b0;
      end
      @(negedge clk);
      got[i-1] = sd1;
      n_cmp++;
      if (w1 !== 4'b0000 || sv1 !== 1'b1) begin
        n_fail++;
        $display("FAIL ignore_c%0d: got word=%b v=%b want 0000 1", i, w1, sv1);
      end
    end
    n_cmp++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL ignore_stream: got %b want 0000", got);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 4'b1010;
    @(negedge clk);
    lv1 = 1'b0;
    ld1 = 4'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sv1 !== 1'b1 || s1 !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_pre: got v=%b sel=%b want 1 10", sv1, s1);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (s1 !== 2'b00 || w1 !== 4'b0 || sv1 !== 1'b0 || bz1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got sel=%b word=%b v=%b busy=%b want 00 0000 0 0",
               s1, w1, sv1, bz1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sv1 !== 1'b0 || lr1 !== 1'b1 || bz1 !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: got v=%b ready=%b busy=%b want 0 1 0", i, sv1, lr1, bz1);
      end
    end
    test_word_bc1(4'b1010, 4'b1010, "post_rst");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    lv1 = 1'b0;
    ld1 = 4'b0;
    lv3 = 1'b0;
    ld3 = 4'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bit_cycles3();
    test_ignore_load();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
